control_edicion: RTL and testbench

//  Edit-mode sequencer for the time/date display mux. Drives the mux's 2-bit select,

---
 rtl/control_edicion_if.sv | 20 ++
 rtl/control_edicion.sv | 230 +++++++++++++++++++++++
 tb/tb_control_edicion.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/control_edicion_if.sv
// RTC-side bundle of control_edicion: RTC time/date snapshot plus the write request/acknowledge pair.
// master = edit controller, slave = RTC driver.
interface control_edicion_if;
  logic [23:0] rtc_hora;
  logic [23:0] rtc_fecha;
  logic        rtc_ampm;
  logic        wr_req;
  logic        wr_tipo;
  logic        wr_ack;

  modport master (
    input  rtc_hora, rtc_fecha, rtc_ampm, wr_ack,
    output wr_req, wr_tipo
  );

  modport slave (
    output rtc_hora, rtc_fecha, rtc_ampm, wr_ack,
    input  wr_req, wr_tipo
  );
endinterface

// File: rtl/control_edicion.sv
// Edit-mode sequencer for the time/date display mux: captures RTC values, applies BCD field edits, requests the RTC write.
// Optional edit timeout is built only when CTRL_EDICION_TIMEOUT_EN is defined.
module control_edicion #(
  parameter int unsigned TIMEOUT_CICLOS = 32'd500_000_000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      btn_prog_hora,
  input  logic                      btn_prog_fecha,
  input  logic                      btn_arriba,
  input  logic                      btn_abajo,
  input  logic                      btn_izq,
  input  logic                      btn_der,
  input  logic                      btn_ok,
  control_edicion_if.master         rtc,
  output logic [23:0]               edit_hora,
  output logic [23:0]               edit_fecha,
  output logic                      edit_ampm,
  output logic [1:0]                seleccion,
  output logic [1:0]                cursor
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ED_HORA  = 2'd1,
    ED_FECHA = 2'd2,
    ESCRIBE  = 2'd3
  } estado_t;

  estado_t     state_r, state_s;
  logic [23:0] hora_s, fecha_s, palabra_s;
  logic        ampm_s, req_s, tipo_s;
  logic [1:0]  sel_s, cursor_s, cursor_mov_s;
  logic [7:0]  campo_s, nuevo_s, lim_min_s, lim_max_s;
  logic        sube_s, baja_s, toggle_s, btn_any_s, en_edicion_s, timeout_s;

  function automatic logic bcd_valido(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmin, input logic [7:0] vmax);
    logic [7:0] r;
    if (!bcd_valido(v) || (v >= vmax)) r = vmin;
    else if (v[3:0] == 4'd9)           r = {v[7:4] + 4'd1, 4'd0};
    else                               r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmin, input logic [7:0] vmax);
    logic [7:0] r;
    if (!bcd_valido(v) || (v <= vmin)) r = vmax;
    else if (v[3:0] == 4'd0)           r = {v[7:4] - 4'd1, 4'd9};
    else                               r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] campo_get(input logic [23:0] w, input logic [1:0] c);
    logic [7:0] r;
    case (c)
      2'd0:    r = w[23:16];
      2'd1:    r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

  function automatic logic [23:0] campo_put(input logic [23:0] w, input logic [1:0] c, input logic [7:0] v);
    logic [23:0] r;
    r = w;
    case (c)
      2'd0:    r[23:16] = v;
      2'd1:    r[15:8]  = v;
      default: r[7:0]   = v;
    endcase
    return r;
  endfunction

  assign btn_any_s    = btn_prog_hora | btn_prog_fecha | btn_arriba | btn_abajo | btn_izq | btn_der | btn_ok;
  assign en_edicion_s = (state_r == ED_HORA) || (state_r == ED_FECHA);

  // Field under the cursor: range limits, inc/dec result and AM/PM toggle on the 11<->12 crossing
  always_comb begin
    sube_s = btn_arriba & ~btn_abajo;
    baja_s = btn_abajo & ~btn_arriba;
    if (state_r == ED_HORA) begin
      palabra_s = edit_hora;
      case (cursor)
        2'd0:    begin lim_min_s = 8'h01; lim_max_s = 8'h12; end
        default: begin lim_min_s = 8'h00; lim_max_s = 8'h59; end
      endcase
    end else begin
      palabra_s = edit_fecha;
      case (cursor)
        2'd0:    begin lim_min_s = 8'h01; lim_max_s = 8'h31; end
        2'd1:    begin lim_min_s = 8'h01; lim_max_s = 8'h12; end
        default: begin lim_min_s = 8'h00; lim_max_s = 8'h99; end
      endcase
    end
    campo_s = campo_get(palabra_s, cursor);
    if (sube_s)      nuevo_s = bcd_inc(campo_s, lim_min_s, lim_max_s);
    else if (baja_s) nuevo_s = bcd_dec(campo_s, lim_min_s, lim_max_s);
    else             nuevo_s = campo_s;
    toggle_s = (state_r == ED_HORA) && (cursor == 2'd0) &&
               ((sube_s && (campo_s == 8'h11)) || (baja_s && (campo_s == 8'h12)));
  end

  // Cursor motion modulo 3; opposite presses cancel
  always_comb begin
    if (btn_izq && !btn_der)      cursor_mov_s = (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
    else if (btn_der && !btn_izq) cursor_mov_s = (cursor >= 2'd2) ? 2'd0 : cursor + 2'd1;
    else                          cursor_mov_s = cursor;
  end

`ifdef CTRL_EDICION_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CICLOS > 32'd1) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  // Idle counter: runs only while editing, any button restarts it
  always_comb begin
    timeout_s = en_edicion_s && !btn_any_s && (cnt_r == CNT_W'(TIMEOUT_CICLOS - 32'd1));
    if (en_edicion_s && !btn_any_s && !timeout_s) cnt_s = cnt_r + CNT_W'(1);
    else                                          cnt_s = '0;
  end

  // Idle counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_r <= '0;
    else          cnt_r <= cnt_s;
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    sel_s    = seleccion;
    cursor_s = cursor;
    hora_s   = edit_hora;
    fecha_s  = edit_fecha;
    ampm_s   = edit_ampm;
    req_s    = rtc.wr_req;
    tipo_s   = rtc.wr_tipo;
    case (state_r)
      IDLE: begin
        if (btn_prog_hora) begin
          state_s  = ED_HORA;
          sel_s    = 2'b01;
          cursor_s = 2'd0;
          hora_s   = rtc.rtc_hora;
          ampm_s   = rtc.rtc_ampm;
        end else if (btn_prog_fecha) begin
          state_s  = ED_FECHA;
          sel_s    = 2'b10;
          cursor_s = 2'd0;
          fecha_s  = rtc.rtc_fecha;
        end else begin
          state_s  = IDLE;
        end
      end
      ED_HORA: begin
        cursor_s = cursor_mov_s;
        hora_s   = campo_put(edit_hora, cursor, nuevo_s);
        ampm_s   = edit_ampm ^ toggle_s;
        if (btn_prog_hora || timeout_s) begin
          state_s = IDLE;
          sel_s   = 2'b00;
        end else if (btn_ok) begin
          state_s = ESCRIBE;
          req_s   = 1'b1;
          tipo_s  = 1'b0;
        end else begin
          state_s = ED_HORA;
        end
      end
      ED_FECHA: begin
        cursor_s = cursor_mov_s;
        fecha_s  = campo_put(edit_fecha, cursor, nuevo_s);
        if (btn_prog_fecha || timeout_s) begin
          state_s = IDLE;
          sel_s   = 2'b00;
        end else if (btn_ok) begin
          state_s = ESCRIBE;
          req_s   = 1'b1;
          tipo_s  = 1'b1;
        end else begin
          state_s = ED_FECHA;
        end
      end
      ESCRIBE: begin
        if (rtc.wr_ack) begin
          state_s = IDLE;
          sel_s   = 2'b00;
          req_s   = 1'b0;
        end else begin
          req_s   = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        sel_s   = 2'b00;
        req_s   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      seleccion   <= 2'b00;
      cursor      <= 2'd0;
      edit_hora   <= 24'h120000;
      edit_fecha  <= 24'h010100;
      edit_ampm   <= 1'b0;
      rtc.wr_req  <= 1'b0;
      rtc.wr_tipo <= 1'b0;
    end else begin
      state_r     <= state_s;
      seleccion   <= sel_s;
      cursor      <= cursor_s;
      edit_hora   <= hora_s;
      edit_fecha  <= fecha_s;
      edit_ampm   <= ampm_s;
      rtc.wr_req  <= req_s;
      rtc.wr_tipo <= tipo_s;
    end
  end

endmodule

// File: tb/tb_control_edicion.sv
// Scoreboard bench for control_edicion: directed button sequences push hand-computed output snapshots,
// a negedge monitor pops and compares them.
module tb_control_edicion;

  logic        clk;
  logic        reset_n;
  logic        btn_prog_hora, btn_prog_fecha, btn_arriba, btn_abajo, btn_izq, btn_der, btn_ok;
  logic [23:0] edit_hora, edit_fecha;
  logic        edit_ampm;
  logic [1:0]  seleccion, cursor;

  control_edicion_if rtc_if ();

  control_edicion #(.TIMEOUT_CICLOS(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .btn_prog_hora  (btn_prog_hora),
    .btn_prog_fecha (btn_prog_fecha),
    .btn_arriba     (btn_arriba),
    .btn_abajo      (btn_abajo),
    .btn_izq        (btn_izq),
    .btn_der        (btn_der),
    .btn_ok         (btn_ok),
    .rtc            (rtc_if.master),
    .edit_hora      (edit_hora),
    .edit_fecha     (edit_fecha),
    .edit_ampm      (edit_ampm),
    .seleccion      (seleccion),
    .cursor         (cursor)
  );

  localparam logic [6:0] NB  = 7'b0000000;
  localparam logic [6:0] PH  = 7'b1000000;
  localparam logic [6:0] PF  = 7'b0100000;
  localparam logic [6:0] UP  = 7'b0010000;
  localparam logic [6:0] DN  = 7'b0001000;
  localparam logic [6:0] IZQ = 7'b0000100;
  localparam logic [6:0] DER = 7'b0000010;
  localparam logic [6:0] OK  = 7'b0000001;

  typedef struct {
    string       nm;
    logic [54:0] val;
    logic        chk_tipo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected snapshot per cycle, compared on the falling edge
  initial begin : monitor
    exp_t        e;
    logic [54:0] act_v, exp_v;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e     = sb.pop_front();
        act_v = {edit_hora, edit_fecha, edit_ampm, seleccion, cursor, rtc_if.wr_req, rtc_if.wr_tipo};
        exp_v = e.val;
        if (!e.chk_tipo) begin
          act_v[0] = 1'b0;
          exp_v[0] = 1'b0;
        end
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s: got hora=%h fecha=%h ampm=%b sel=%b cur=%0d req=%b tipo=%b, required hora=%h fecha=%h ampm=%b sel=%b cur=%0d req=%b tipo=%b",
                   e.nm, act_v[54:31], act_v[30:7], act_v[6], act_v[5:4], act_v[3:2], act_v[1], act_v[0],
                   exp_v[54:31], exp_v[30:7], exp_v[6], exp_v[5:4], exp_v[3:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input logic [23:0] h, input logic [23:0] f, input logic a,
                          input logic [1:0] s, input logic [1:0] c, input logic r, input logic t,
                          input logic chk_t);
    exp_t e;
    e.nm       = nm;
    e.val      = {h, f, a, s, c, r, t};
    e.chk_tipo = chk_t;
    sb.push_back(e);
  endtask

  // One cycle of stimulus; the expectation describes the outputs after the sampling edge
  task automatic st(input string nm, input logic [6:0] b, input logic ack,
                    input logic [23:0] h, input logic [23:0] f, input logic a,
                    input logic [1:0] s, input logic [1:0] c, input logic r, input logic t);
    {btn_prog_hora, btn_prog_fecha, btn_arriba, btn_abajo, btn_izq, btn_der, btn_ok} = b;
    rtc_if.wr_ack = ack;
    @(posedge clk);
    #1;
    push_exp(nm, h, f, a, s, c, r, t, r);
    {btn_prog_hora, btn_prog_fecha, btn_arriba, btn_abajo, btn_izq, btn_der, btn_ok} = NB;
    rtc_if.wr_ack = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    push_exp(nm, 24'h120000, 24'h010100, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    reset_n = 1'b0;
    {btn_prog_hora, btn_prog_fecha, btn_arriba, btn_abajo, btn_izq, btn_der, btn_ok} = NB;
    rtc_if.wr_ack    = 1'b0;
    rtc_if.rtc_hora  = 24'h115930;
    rtc_if.rtc_fecha = 24'h310199;
    rtc_if.rtc_ampm  = 1'b0;

    do_reset("reset");

    // time edit: AM/PM crossing, minute wrap, cursor wrap, combined presses
    st("prog_hora",   PH,      1'b0, 24'h115930, 24'h010100, 1'b1 ^ 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("ampm_11_12",  UP,      1'b0, 24'h125930, 24'h010100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("der",         DER,     1'b0, 24'h125930, 24'h010100, 1'b1, 2'b01, 2'd1, 1'b0, 1'b0);
    st("min_59_up",   UP,      1'b0, 24'h120030, 24'h010100, 1'b1, 2'b01, 2'd1, 1'b0, 1'b0);
    st("min_00_dn",   DN,      1'b0, 24'h125930, 24'h010100, 1'b1, 2'b01, 2'd1, 1'b0, 1'b0);
    st("izq",         IZQ,     1'b0, 24'h125930, 24'h010100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("izq_wrap",    IZQ,     1'b0, 24'h125930, 24'h010100, 1'b1, 2'b01, 2'd2, 1'b0, 1'b0);
    st("seg_dn",      DN,      1'b0, 24'h125929, 24'h010100, 1'b1, 2'b01, 2'd2, 1'b0, 1'b0);
    st("dn_der",      DN|DER,  1'b0, 24'h125928, 24'h010100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("hora_12_01",  UP,      1'b0, 24'h015928, 24'h010100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("hora_01_12",  DN,      1'b0, 24'h125928, 24'h010100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("ampm_12_11",  DN,      1'b0, 24'h115928, 24'h010100, 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
    st("up_dn",       UP|DN,   1'b0, 24'h115928, 24'h010100, 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
    st("izq_der",     IZQ|DER, 1'b0, 24'h115928, 24'h010100, 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
    st("other_prog",  PF,      1'b0, 24'h115928, 24'h010100, 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
    st("cancel_hora", PH,      1'b0, 24'h115928, 24'h010100, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
    st("idle",        NB,      1'b0, 24'h115928, 24'h010100, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);

    // date edit committed, write held five cycles until acknowledged
    st("prog_fecha",  PF,      1'b0, 24'h115928, 24'h310199, 1'b0, 2'b10, 2'd0, 1'b0, 1'b0);
    st("der1",        DER,     1'b0, 24'h115928, 24'h310199, 1'b0, 2'b10, 2'd1, 1'b0, 1'b0);
    st("der2",        DER,     1'b0, 24'h115928, 24'h310199, 1'b0, 2'b10, 2'd2, 1'b0, 1'b0);
    st("year_99_00",  UP,      1'b0, 24'h115928, 24'h310100, 1'b0, 2'b10, 2'd2, 1'b0, 1'b0);
    st("ok_fecha",    OK,      1'b0, 24'h115928, 24'h310100, 1'b0, 2'b10, 2'd2, 1'b1, 1'b1);
    st("esc_hold1",   UP,      1'b0, 24'h115928, 24'h310100, 1'b0, 2'b10, 2'd2, 1'b1, 1'b1);
    st("esc_hold2",   PH,      1'b0, 24'h115928, 24'h310100, 1'b0, 2'b10, 2'd2, 1'b1, 1'b1);
    st("esc_hold3",   DN|IZQ,  1'b0, 24'h115928, 24'h310100, 1'b0, 2'b10, 2'd2, 1'b1, 1'b1);
    st("esc_hold4",   PF,      1'b0, 24'h115928, 24'h310100, 1'b0, 2'b10, 2'd2, 1'b1, 1'b1);
    st("wr_ack",      NB,      1'b1, 24'h115928, 24'h310100, 1'b0, 2'b00, 2'd2, 1'b0, 1'b0);
    st("after_ack",   NB,      1'b0, 24'h115928, 24'h310100, 1'b0, 2'b00, 2'd2, 1'b0, 1'b0);

    // invalid/out-of-range captured values, time write
    rtc_if.rtc_hora = 24'h0A4560;
    rtc_if.rtc_ampm = 1'b1;
    st("prog_hora_bad", PH,    1'b0, 24'h0A4560, 24'h310100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("hora_bad_up",   UP,    1'b0, 24'h014560, 24'h310100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("izq_to_seg",    IZQ,   1'b0, 24'h014560, 24'h310100, 1'b1, 2'b01, 2'd2, 1'b0, 1'b0);
    st("seg_60_up",     UP,    1'b0, 24'h014500, 24'h310100, 1'b1, 2'b01, 2'd2, 1'b0, 1'b0);
    st("seg_00_dn",     DN,    1'b0, 24'h014559, 24'h310100, 1'b1, 2'b01, 2'd2, 1'b0, 1'b0);
    st("der_wrap",      DER,   1'b0, 24'h014559, 24'h310100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("hora_01_dn",    DN,    1'b0, 24'h124559, 24'h310100, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0);
    st("ok_hora",       OK,    1'b0, 24'h124559, 24'h310100, 1'b1, 2'b01, 2'd0, 1'b1, 1'b0);
    st("ack_hora",      NB,    1'b1, 24'h124559, 24'h310100, 1'b1, 2'b00, 2'd0, 1'b0, 1'b0);

    // day/month wrap, date cancel
    st("prog_fecha2",   PF,    1'b0, 24'h124559, 24'h310199, 1'b1, 2'b10, 2'd0, 1'b0, 1'b0);
    st("dia_31_up",     UP,    1'b0, 24'h124559, 24'h010199, 1'b1, 2'b10, 2'd0, 1'b0, 1'b0);
    st("dia_01_dn",     DN,    1'b0, 24'h124559, 24'h310199, 1'b1, 2'b10, 2'd0, 1'b0, 1'b0);
    st("der_mes",       DER,   1'b0, 24'h124559, 24'h310199, 1'b1, 2'b10, 2'd1, 1'b0, 1'b0);
    st("mes_01_dn",     DN,    1'b0, 24'h124559, 24'h311299, 1'b1, 2'b10, 2'd1, 1'b0, 1'b0);
    st("mes_12_up",     UP,    1'b0, 24'h124559, 24'h310199, 1'b1, 2'b10, 2'd1, 1'b0, 1'b0);
    st("cancel_fecha",  PF,    1'b0, 24'h124559, 24'h310199, 1'b1, 2'b00, 2'd1, 1'b0, 1'b0);
    st("idle2",         NB,    1'b0, 24'h124559, 24'h310199, 1'b1, 2'b00, 2'd1, 1'b0, 1'b0);

    // both prog buttons: time edit wins; reset in the middle of a write
    rtc_if.rtc_hora = 24'h083015;
    rtc_if.rtc_ampm = 1'b0;
    st("both_prog",     PH|PF, 1'b0, 24'h083015, 24'h310199, 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
    st("ok_last",       OK,    1'b0, 24'h083015, 24'h310199, 1'b0, 2'b01, 2'd0, 1'b1, 1'b0);
    st("esc_wait",      NB,    1'b0, 24'h083015, 24'h310199, 1'b0, 2'b01, 2'd0, 1'b1, 1'b0);
    do_reset("reset_mid_write");

    // idle edit: aborts after 16 silent cycles only when the timeout is built in
    st("prog_hora_to",  PH,    1'b0, 24'h083015, 24'h010100, 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
`ifdef CTRL_EDICION_TIMEOUT_EN
    for (int i = 0; i < 15; i++)
      st("to_wait",     NB,    1'b0, 24'h083015, 24'h010100, 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
    st("timeout",       NB,    1'b0, 24'h083015, 24'h010100, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
    st("to_idle",       NB,    1'b0, 24'h083015, 24'h010100, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0);
`else
    for (int i = 0; i < 20; i++)
      st("no_timeout",  NB,    1'b0, 24'h083015, 24'h010100, 1'b0, 2'b01, 2'd0, 1'b0, 1'b0);
`endif

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
